inst_tracking_queue: RTL and testbench
======================================

# inst_tracking_queue

Parametrised in-order instruction tracking queue for the RISC-V core, the successor to the fixed single-writeback instruction queue. It sits between decode/issue and the writeback arbiter. It allocates an instruction ID per issued instruction and accepts out-of-order completion reports from up to `WB_UNITS` execution units. It retires instructions strictly in issue order, presenting `rd_addr`, `unit_id` and `id` for register-file writeback.

## Interface
Parameters:
- `DEPTH`, default 8: entry count; power of two, at least 2.
- `WB_UNITS`, default 4: number of completion-report ports.
- `ID_W`, default `$clog2(DEPTH)`: width of the instruction ID.
- `UNIT_W`, default `$clog2(WB_UNITS)`: width of the unit ID.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `issue_valid`  in  1  issue request.
- `issue_unit_id`  in  `UNIT_W`  unit that will execute the instruction.
- `issue_rd_addr`  in  5  destination register.
- `issue_ready`  out  1  queue not full.
- `issue_id`  out  `ID_W`  ID given to the instruction issued this cycle (the current tail).
- `done_valid`  in  `WB_UNITS`  per-unit completion strobe.
- `done_id`  in  `WB_UNITS*ID_W`  per-unit completed ID; unit u uses bits `[u*ID_W +: ID_W]`.
- `retire_valid`  out  1  head entry is complete.
- `retire_ready`  in  1  writeback accepts the head.
- `retire_unit_id`  out  `UNIT_W`  head entry's unit ID.
- `retire_rd_addr`  out  5  head entry's destination register.
- `retire_id`  out  `ID_W`  head entry's ID.
- `count`  out  `ID_W+1`  number of occupied entries.
- `empty`  out  1  `count == 0`.
- `flush`  in  1  discard all entries; present only with `TRACKING_QUEUE_FLUSH_EN`.

## Operation
- Per entry state: `valid`, `done`, `unit_id`, `rd_addr`. Pointers: `head`, `tail` (`ID_W` bits each, wrap modulo `DEPTH`) and `count`.
- Issue fires on `issue_valid && issue_ready`:
  - writes the entry at `tail` with `valid=1`, `done=0`;
  - `tail` increments; `issue_id` equals `tail` before the increment.
- Completion: for each u with `done_valid[u]`, set `done` on entry `done_id[u]` if that entry is valid.
  - Reports to invalid entries are ignored.
  - Several units may report distinct IDs in the same cycle; all take effect.
  - Duplicate IDs in the same cycle behave as a single report.
- Retire:
  - `retire_valid = valid[head] && done[head]`; retire fields read combinationally from `head`.
  - Retire fires on `retire_valid && retire_ready`: clears `valid` and `done` of the head entry, and `head` increments.
- `count` updates as +1 on issue, -1 on retire, unchanged when both fire in the same cycle.
- `issue_ready = (count != DEPTH)`. There is no bypass: when full, a retire in the same cycle does not allow an issue that cycle.
- Retiring entry vs. issue to the same slot: this cannot happen, because the slot at `tail` is free whenever `issue_ready` is high.

## Timing
- Reset values:
  - all `valid` and `done` bits 0; `head = tail = 0`; `count = 0`;
  - `empty = 1`, `issue_ready = 1`, `issue_id = 0`;
  - `retire_valid = 0`; retire fields 0.
- Completion latency: a report in cycle n gives `retire_valid` in cycle n+1 at the earliest, if that entry is the head.
- Minimum issue-to-retire latency is 2 cycles: issue in n, done in n+1, retire in n+2.
- Sustained throughput: one issue and one retire per cycle.
- Reset asserted mid-operation clears all state immediately. Outputs return to their reset values asynchronously.

## Configuration
- `TRACKING_QUEUE_FLUSH_EN` defined:
  - the `flush` port exists;
  - `flush` high in cycle n clears all `valid` and `done` bits and sets `head = tail = count = 0` at the end of cycle n;
  - flush takes priority over any issue, completion or retire in the same cycle; those events are discarded and no retire handshake is counted.
  - `retire_valid` stays combinational during the flush cycle; writeback must qualify it with `!flush`.
- Not defined: no `flush` port and no flush logic.

## Structure
- Shared package `riscv_types`:
  - `tracking_retire_t` packed struct (`unit_id`, `rd_addr`, `id`) for the default configuration, built on the existing `instruction_id_t` and `WB_UNITS_WIDTH`;
  - constant `TRACKING_QUEUE_DEPTH_MIN = 2`.
- Sub-module `inst_done_table`: holds the `DEPTH` done bits, with `WB_UNITS` set ports, one clear port (retire) and clear-all (flush).
  - A set and a clear to the same entry in the same cycle resolves to clear. This case is unreachable in legal use.

## Test plan
- Reset, then idle → `empty=1`, `issue_ready=1`, `issue_id=0`, `retire_valid=0`, `count=0`.
- Issue 3 instructions (rd 5, 6, 7; units 0, 1, 2); report done in the order ID 2, 1, 0 across three cycles → `retire_valid` first rises the cycle after ID 0's report. Retires follow in order: rd 5, 6, 7.
- With `DEPTH=8`, fill 8 entries → `issue_ready=0`, `count=8`. Retire 1 with `issue_valid` held high → the issue waits until the next cycle and receives `issue_id=0` (wrap-around).
- Units 0–3 report IDs 0–3 in a single cycle → the next 4 cycles retire IDs 0–3 back-to-back with `retire_ready=1`.
- Report `done_id=6` while entry 6 is invalid, then issue up to ID 6 → entry 6 stays not-done until it is reported again.
- With the macro: 5 entries outstanding; assert `flush` together with an issue and a retire → the next cycle has `count=0`, `empty=1`, `issue_id=0`, and the issue is not recorded.

Source files
------------

// File: rtl/riscv_types_pkg.sv
// Shared RISC-V core types used by the instruction tracking queue and its users.
// tracking_retire_t describes one retiring entry for the default core
// configuration (8-entry queue, 4 writeback units).
package riscv_types;

    localparam int INSTRUCTION_QUEUE_DEPTH  = 8;
    localparam int INSTRUCTION_ID_WIDTH     = $clog2(INSTRUCTION_QUEUE_DEPTH);
    localparam int WB_UNITS_COUNT           = 4;
    localparam int WB_UNITS_WIDTH           = $clog2(WB_UNITS_COUNT);
    localparam int TRACKING_QUEUE_DEPTH_MIN = 2;

    typedef logic [INSTRUCTION_ID_WIDTH-1:0] instruction_id_t;
    typedef logic [4:0]                      reg_addr_t;

    typedef struct packed {
        logic [WB_UNITS_WIDTH-1:0] unit_id;
        reg_addr_t                 rd_addr;
        instruction_id_t           id;
    } tracking_retire_t;

endpackage

// File: rtl/inst_tracking_queue_done_table.sv
// Completion bits for the tracking queue. Any number of writeback units may
// set bits in one cycle; retire clears the head bit and flush clears all.
// Reports aimed at entries that are not currently allocated are dropped.
module inst_done_table #(
    parameter int DEPTH    = 8,
    parameter int WB_UNITS = 4,
    parameter int ID_W     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEPTH-1:0]         entry_valid,
    input  logic [WB_UNITS-1:0]      set_valid,
    input  logic [WB_UNITS*ID_W-1:0] set_id,
    input  logic                     clr_valid,
    input  logic [ID_W-1:0]          clr_id,
    input  logic                     clr_all,
    output logic [DEPTH-1:0]         done
);

    logic [DEPTH-1:0] done_next;

    // Merge all set ports, then clear; clear wins on a same-entry collision.
    always_comb begin
        done_next = done;
        for (int u = 0; u < WB_UNITS; u++) begin
            if (set_valid[u] && entry_valid[set_id[u*ID_W +: ID_W]]) begin
                done_next[set_id[u*ID_W +: ID_W]] = 1'b1;
            end
        end
        if (clr_valid) begin
            done_next[clr_id] = 1'b0;
        end
        if (clr_all) begin
            done_next = '0;
        end
    end

    // Done bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= '0;
        end else begin
            done <= done_next;
        end
    end

endmodule

// File: rtl/inst_tracking_queue.sv
// In-order instruction tracking queue. Allocates an ID at issue, accepts
// out-of-order completion reports from WB_UNITS execution units, and retires
// strictly in issue order. No issue bypass when full.
// Optional feature: define TRACKING_QUEUE_FLUSH_EN to add the flush port,
// which discards every entry and resets the pointers at the end of the cycle.
module inst_tracking_queue
    import riscv_types::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_UNITS = 4,
    parameter int ID_W     = $clog2(DEPTH),
    parameter int UNIT_W   = $clog2(WB_UNITS)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef TRACKING_QUEUE_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic                     issue_valid,
    input  logic [UNIT_W-1:0]        issue_unit_id,
    input  logic [4:0]               issue_rd_addr,
    output logic                     issue_ready,
    output logic [ID_W-1:0]          issue_id,
    input  logic [WB_UNITS-1:0]      done_valid,
    input  logic [WB_UNITS*ID_W-1:0] done_id,
    output logic                     retire_valid,
    input  logic                     retire_ready,
    output logic [UNIT_W-1:0]        retire_unit_id,
    output logic [4:0]               retire_rd_addr,
    output logic [ID_W-1:0]          retire_id,
    output logic [ID_W:0]            count,
    output logic                     empty
);

    localparam logic [ID_W:0] FULL_COUNT = (ID_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_w;
    logic [UNIT_W-1:0] unit_q [DEPTH];
    reg_addr_t         rd_q   [DEPTH];
    logic [ID_W-1:0]   head_q;
    logic [ID_W-1:0]   tail_q;
    logic [ID_W:0]     count_q;
    logic              flush_w;
    logic              issue_fire;
    logic              retire_fire;

`ifdef TRACKING_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign issue_ready    = (count_q != FULL_COUNT);
    assign issue_id       = tail_q;
    assign retire_valid   = valid_q[head_q] && done_w[head_q];
    assign retire_unit_id = unit_q[head_q];
    assign retire_rd_addr = rd_q[head_q];
    assign retire_id      = head_q;
    assign count          = count_q;
    assign empty          = (count_q == '0);

    assign issue_fire  = issue_valid && issue_ready;
    assign retire_fire = retire_valid && retire_ready;

    // Valid bits, pointers and occupancy; flush overrides any same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_w) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (retire_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ID_W'(1);
            end
            if (issue_fire) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + ID_W'(1);
            end
            case ({issue_fire, retire_fire})
                2'b10:   count_q <= count_q + (ID_W+1)'(1);
                2'b01:   count_q <= count_q - (ID_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload captured at issue; reset so retire fields read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                unit_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else if (issue_fire && !flush_w) begin
            unit_q[tail_q] <= issue_unit_id;
            rd_q[tail_q]   <= issue_rd_addr;
        end
    end

    inst_done_table #(
        .DEPTH    (DEPTH),
        .WB_UNITS (WB_UNITS),
        .ID_W     (ID_W)
    ) u_done_table (
        .clk         (clk),
        .rst         (rst),
        .entry_valid (valid_q),
        .set_valid   (done_valid),
        .set_id      (done_id),
        .clr_valid   (retire_fire),
        .clr_id      (head_q),
        .clr_all     (flush_w),
        .done        (done_w)
    );

endmodule

// File: tb/tb_inst_tracking_queue.sv
// Self-checking bench for inst_tracking_queue (default parameters).
// A scoreboard queue holds the expected retire records in issue order; a
// small behavioural model tracks occupancy and completion state.
module tb_inst_tracking_queue;
    import riscv_types::*;

    localparam int DEPTH  = 8;
    localparam int WB     = 4;
    localparam int ID_W   = 3;
    localparam int UNIT_W = 2;

    logic              clk;
    logic              rst;
    logic              flush_r;
    logic              issue_valid;
    logic [UNIT_W-1:0] issue_unit_id;
    logic [4:0]        issue_rd_addr;
    logic              issue_ready;
    logic [ID_W-1:0]   issue_id;
    logic [WB-1:0]     done_valid;
    logic [WB*ID_W-1:0] done_id;
    logic              retire_valid;
    logic              retire_ready;
    logic [UNIT_W-1:0] retire_unit_id;
    logic [4:0]        retire_rd_addr;
    logic [ID_W-1:0]   retire_id;
    logic [ID_W:0]     count;
    logic              empty;

    inst_tracking_queue #(
        .DEPTH    (DEPTH),
        .WB_UNITS (WB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef TRACKING_QUEUE_FLUSH_EN
        .flush          (flush_r),
`endif
        .issue_valid    (issue_valid),
        .issue_unit_id  (issue_unit_id),
        .issue_rd_addr  (issue_rd_addr),
        .issue_ready    (issue_ready),
        .issue_id       (issue_id),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .retire_valid   (retire_valid),
        .retire_ready   (retire_ready),
        .retire_unit_id (retire_unit_id),
        .retire_rd_addr (retire_rd_addr),
        .retire_id      (retire_id),
        .count          (count),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit               m_valid [DEPTH];
    bit               m_done  [DEPTH];
    logic [ID_W-1:0]  m_head;
    logic [ID_W-1:0]  m_tail;
    int               m_count;
    tracking_retire_t sb_q [$];

    typedef struct {
        int iv;
        int iu;
        int ird;
        int dv;
        int did;
        int rr;
        int e_rv;
        int e_count;
        int e_iid;
        int e_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_ids(input int a0, input int a1, input int a2, input int a3);
        return (a3 << 9) | (a2 << 6) | (a1 << 3) | a0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
        end
        m_head  = '0;
        m_tail  = '0;
        m_count = 0;
        sb_q.delete();
    endtask

    task automatic drive(input int iv, input int iu, input int ird, input int dv,
                         input int did, input int rr, input int fl);
        issue_valid   = (iv != 0);
        issue_unit_id = 2'(iu);
        issue_rd_addr = 5'(ird);
        done_valid    = 4'(dv);
        done_id       = 12'(did);
        retire_ready  = (rr != 0);
        flush_r       = (fl != 0);
    endtask

    // Compare against the model at mid-cycle, then advance the model and the clock.
    task automatic commit();
        bit               rv_exp;
        bit               ifire;
        bit               rfire;
        logic [ID_W-1:0]  did;
        tracking_retire_t rec;
        rv_exp = m_valid[m_head] && m_done[m_head];
        chk("count", 32'(count), m_count);
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("issue_ready", 32'(issue_ready), 32'(m_count != DEPTH));
        chk("issue_id", 32'(issue_id), 32'(m_tail));
        chk("retire_valid", 32'(retire_valid), 32'(rv_exp));
        if (flush_r) begin
            model_reset();
        end else begin
            ifire = issue_valid && (m_count != DEPTH);
            rfire = rv_exp && retire_ready;
            if (rfire) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow actual retire required none at %0t", $time);
                end else begin
                    rec = sb_q.pop_front();
                    chk("retire_unit_id", 32'(retire_unit_id), 32'(rec.unit_id));
                    chk("retire_rd_addr", 32'(retire_rd_addr), 32'(rec.rd_addr));
                    chk("retire_id", 32'(retire_id), 32'(rec.id));
                end
            end
            for (int u = 0; u < WB; u++) begin
                did = done_id[u*ID_W +: ID_W];
                if (done_valid[u] && m_valid[did]) m_done[did] = 1'b1;
            end
            if (rfire) begin
                m_valid[m_head] = 1'b0;
                m_done[m_head]  = 1'b0;
                m_head = m_head + 3'd1;
            end
            if (ifire) begin
                m_valid[m_tail] = 1'b1;
                m_done[m_tail]  = 1'b0;
                rec.unit_id = issue_unit_id;
                rec.rd_addr = issue_rd_addr;
                rec.id      = m_tail;
                sb_q.push_back(rec);
                m_tail = m_tail + 3'd1;
            end
            if (ifire && !rfire) m_count++;
            if (rfire && !ifire) m_count--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int iv, input int iu, input int ird, input int dv,
                       input int did, input int rr);
        drive(iv, iu, ird, dv, did, rr, 0);
        @(negedge clk);
        commit();
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_issue_ready"}, 32'(issue_ready), 1);
        chk({tag, "_issue_id"}, 32'(issue_id), 0);
        chk({tag, "_retire_valid"}, 32'(retire_valid), 0);
        chk({tag, "_retire_unit"}, 32'(retire_unit_id), 0);
        chk({tag, "_retire_rd"}, 32'(retire_rd_addr), 0);
        chk({tag, "_retire_id"}, 32'(retire_id), 0);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic mid_reset(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        reset_values(tag);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_values("por");
        rst = 1'b0;
        run(0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0);

        // Out-of-order completion, in-order retire.
        vecs[0] = '{1, 0, 5, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 6, 0, 0, 0, 0, 1, 1, 0};
        vecs[2] = '{1, 2, 7, 0, 0, 0, 0, 2, 2, 0};
        vecs[3] = '{0, 0, 0, 4, pack_ids(0, 0, 2, 0), 0, 0, 3, 3, 0};
        vecs[4] = '{0, 0, 0, 2, pack_ids(0, 1, 0, 0), 0, 0, 3, 3, 0};
        vecs[5] = '{0, 0, 0, 1, pack_ids(0, 0, 0, 0), 0, 0, 3, 3, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 1, 1, 3, 3, 5};
        vecs[7] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 6};
        vecs[8] = '{0, 0, 0, 0, 0, 1, 1, 1, 3, 7};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].iu, vecs[i].ird, vecs[i].dv, vecs[i].did, vecs[i].rr, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_retire_valid", i), 32'(retire_valid), vecs[i].e_rv);
            chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_issue_id", i), 32'(issue_id), vecs[i].e_iid);
            if (vecs[i].e_rv != 0)
                chk($sformatf("vec%0d_retire_rd", i), 32'(retire_rd_addr), vecs[i].e_rd);
            commit();
        end

        // Full queue, no bypass, wrap-around of the issue ID.
        mid_reset("rst_full");
        for (int i = 0; i < 8; i++) run(1, i % 4, 10 + i, 0, 0, 0);
        drive(1, 0, 20, 1, pack_ids(0, 0, 0, 0), 0, 0);
        @(negedge clk);
        chk("full_issue_ready", 32'(issue_ready), 0);
        chk("full_count", 32'(count), 8);
        commit();
        drive(1, 0, 20, 0, 0, 1, 0);
        @(negedge clk);
        chk("full_retire_issue_ready", 32'(issue_ready), 0);
        chk("full_retire_valid", 32'(retire_valid), 1);
        chk("full_retire_id", 32'(retire_id), 0);
        commit();
        drive(1, 0, 20, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_issue_ready", 32'(issue_ready), 1);
        chk("wrap_issue_id", 32'(issue_id), 0);
        chk("wrap_count", 32'(count), 7);
        commit();
        run(0, 0, 0, 15, pack_ids(1, 2, 3, 4), 0);
        run(0, 0, 0, 15, pack_ids(5, 6, 7, 0), 0);
        for (int i = 0; i < 8; i++) run(0, 0, 0, 0, 0, 1);
        run(0, 0, 0, 0, 0, 0);

        // Four simultaneous reports, then back-to-back retires.
        mid_reset("rst_multi");
        for (int i = 0; i < 4; i++) run(1, i, i + 1, 0, 0, 0);
        run(0, 0, 0, 15, pack_ids(0, 1, 2, 3), 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            chk("b2b_retire_valid", 32'(retire_valid), 1);
            chk("b2b_retire_id", 32'(retire_id), k);
            commit();
        end
        run(0, 0, 0, 0, 0, 0);

        // Report to an unallocated entry is dropped; duplicate IDs act once.
        mid_reset("rst_stale");
        run(0, 0, 0, 1, pack_ids(6, 0, 0, 0), 0);
        for (int i = 0; i < 7; i++) run(1, i % 4, 20 + i, 0, 0, 0);
        run(0, 0, 0, 15, pack_ids(0, 1, 2, 3), 0);
        run(0, 0, 0, 7, pack_ids(4, 4, 5, 0), 0);
        for (int i = 0; i < 6; i++) run(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            chk("stale_retire_valid", 32'(retire_valid), 0);
            chk("stale_head_id", 32'(retire_id), 6);
            commit();
        end
        run(0, 0, 0, 8, pack_ids(0, 0, 0, 6), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rereport_retire_valid", 32'(retire_valid), 1);
        chk("rereport_retire_rd", 32'(retire_rd_addr), 26);
        commit();
        run(0, 0, 0, 0, 0, 0);

`ifdef TRACKING_QUEUE_FLUSH_EN
        // Flush beats a same-cycle issue and retire.
        mid_reset("rst_flush");
        for (int i = 0; i < 5; i++) run(1, i % 4, 1 + i, 0, 0, 0);
        run(0, 0, 0, 1, pack_ids(0, 0, 0, 0), 0);
        drive(1, 1, 9, 0, 0, 1, 1);
        @(negedge clk);
        chk("flush_cycle_retire_valid", 32'(retire_valid), 1);
        commit();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_flush_count", 32'(count), 0);
        chk("post_flush_empty", 32'(empty), 1);
        chk("post_flush_issue_id", 32'(issue_id), 0);
        chk("post_flush_retire_valid", 32'(retire_valid), 0);
        commit();
`endif

        // Random traffic against the model, ending in a mid-operation reset.
        mid_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            run(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 4095)), ($urandom_range(0, 3) != 0) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) run(1, 1, 3, 0, 0, 0);
        mid_reset("rst_midop");
        run(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
